// File: rtl/ic_tag_ecc_pkg.sv
// rtl/ic_tag_ecc_pkg.sv - shared I-cache tag ECC code: H columns, inversion mask, encoder
package ic_tag_ecc_pkg;

    localparam int DATA_W = 21;
    localparam int ADDR_W = 8;
    localparam int ECC_W  = 7;
    localparam int CNT_W  = 8;
    localparam int IDX_W  = 5;

    // Data then address columns are the first 29 weight-3 codes in ascending order; check columns are unit vectors.
    localparam logic [ECC_W-1:0] DATA_COL [DATA_W] = '{
        7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19, 7'h1A, 7'h1C, 7'h23,
        7'h25, 7'h26, 7'h29, 7'h2A, 7'h2C, 7'h31, 7'h32, 7'h34, 7'h38, 7'h43
    };
    localparam logic [ECC_W-1:0] ADDR_COL [ADDR_W] = '{
        7'h45, 7'h46, 7'h49, 7'h4A, 7'h4C, 7'h51, 7'h52, 7'h54
    };

    // Even-weight mask pushes stuck-at-0 and stuck-at-1 words onto even nonzero syndromes.
    localparam logic [ECC_W-1:0] INV_MASK = 7'h03;

    typedef enum logic [2:0] {
        CLS_CLEAN   = 3'd0,
        CLS_SB_DATA = 3'd1,
        CLS_SB_ECC  = 3'd2,
        CLS_ADDR    = 3'd3,
        CLS_DB      = 3'd4
    } ecc_class_e;

    function automatic logic [ECC_W-1:0] ecc_encode(input logic [DATA_W-1:0] data,
                                                   input logic [ADDR_W-1:0] addr);
        logic [ECC_W-1:0] p;
        p = INV_MASK;
        for (int i = 0; i < DATA_W; i++)
            if (data[i]) p = p ^ DATA_COL[i];
        for (int j = 0; j < ADDR_W; j++)
            if (addr[j]) p = p ^ ADDR_COL[j];
        return p;
    endfunction

endpackage

// File: rtl/ic_tag_ecc_syndrome.sv
// rtl/ic_tag_ecc_syndrome.sv - combinational syndrome and H-column lookup
module ic_tag_ecc_syndrome
    import ic_tag_ecc_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [ECC_W-1:0]  ecc,
    input  logic [ADDR_W-1:0] addr,
    output logic [ECC_W-1:0]  syndrome,
    output ecc_class_e        cls,
    output logic [IDX_W-1:0]  bit_idx
);

    logic [ECC_W-1:0] syn;
    logic             odd;

    assign syn      = ecc_encode(data, addr) ^ ecc;
    assign odd      = ^syn;
    assign syndrome = syn;

    always_comb begin
        cls     = CLS_DB;
        bit_idx = '0;
        if (syn == '0) begin
            cls = CLS_CLEAN;
        end else begin
            for (int i = 0; i < DATA_W; i++) begin
                if (odd && syn == DATA_COL[i]) begin
                    cls     = CLS_SB_DATA;
                    bit_idx = IDX_W'(i);
                end
            end
            if (odd && $onehot(syn))
                cls = CLS_SB_ECC;
            for (int j = 0; j < ADDR_W; j++)
                if (syn == ADDR_COL[j])
                    cls = CLS_ADDR;
        end
    end

endmodule

// File: rtl/ic_tag_ecc_checker.sv
// rtl/ic_tag_ecc_checker.sv - 2-stage SECDED tag checker; IC_TAG_ECC_ERR_CNT_EN adds error counters
module ic_tag_ecc_checker
    import ic_tag_ecc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_a,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ECC_W-1:0]  in_ecc,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sb_err,
    output logic              out_db_err,
    output logic              out_addr_err,
    output logic [ECC_W-1:0]  out_syndrome,
    input  logic              err_clr,
`ifdef IC_TAG_ECC_ERR_CNT_EN
    output logic [CNT_W-1:0]  sb_cnt,
    output logic [CNT_W-1:0]  db_cnt,
    output logic [CNT_W-1:0]  addr_cnt,
`endif
    output logic              cap_valid,
    output logic [ADDR_W-1:0] cap_addr,
    output logic [ECC_W-1:0]  cap_syndrome
);

    logic [ECC_W-1:0]  syn_c;
    ecc_class_e        cls_c;
    logic [IDX_W-1:0]  idx_c;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [ADDR_W-1:0] s1_addr;
    logic [ECC_W-1:0]  s1_syn;
    ecc_class_e        s1_cls;
    logic [IDX_W-1:0]  s1_idx;
    logic [ADDR_W-1:0] s2_addr;

    logic              s2_ready, s1_adv, in_fire, out_fire, any_flag;
    logic [DATA_W-1:0] flip_mask;

    ic_tag_ecc_syndrome u_syndrome (
        .data     (in_data),
        .ecc      (in_ecc),
        .addr     (in_addr),
        .syndrome (syn_c),
        .cls      (cls_c),
        .bit_idx  (idx_c)
    );

    assign s2_ready  = !out_valid || out_ready;
    assign s1_adv    = s1_valid && s2_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign any_flag  = out_sb_err || out_db_err || out_addr_err;
    assign flip_mask = (s1_cls == CLS_SB_DATA) ? (DATA_W'(1) << s1_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst_a) begin
            s1_valid     <= 1'b0;
            s1_data      <= '0;
            s1_addr      <= '0;
            s1_syn       <= '0;
            s1_cls       <= CLS_CLEAN;
            s1_idx       <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sb_err   <= 1'b0;
            out_db_err   <= 1'b0;
            out_addr_err <= 1'b0;
            out_syndrome <= '0;
            s2_addr      <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_fire) begin
                    s1_data <= in_data;
                    s1_addr <= in_addr;
                    s1_syn  <= syn_c;
                    s1_cls  <= cls_c;
                    s1_idx  <= idx_c;
                end
            end
            if (s2_ready) begin
                out_valid <= s1_valid;
                if (s1_adv) begin
                    out_data     <= s1_data ^ flip_mask;
                    out_sb_err   <= (s1_cls == CLS_SB_DATA) || (s1_cls == CLS_SB_ECC);
                    out_db_err   <= (s1_cls == CLS_DB);
                    out_addr_err <= (s1_cls == CLS_ADDR);
                    out_syndrome <= s1_syn;
                    s2_addr      <= s1_addr;
                end
            end
        end
    end

    // First flagged result delivered since the last clear; a clear in the same cycle wins.
    always_ff @(posedge clk) begin
        if (rst_a || err_clr) begin
            cap_valid    <= 1'b0;
            cap_addr     <= '0;
            cap_syndrome <= '0;
        end else if (out_fire && any_flag && !cap_valid) begin
            cap_valid    <= 1'b1;
            cap_addr     <= s2_addr;
            cap_syndrome <= out_syndrome;
        end
    end

`ifdef IC_TAG_ECC_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst_a || err_clr) begin
            sb_cnt   <= '0;
            db_cnt   <= '0;
            addr_cnt <= '0;
        end else if (out_fire) begin
            if (out_sb_err && sb_cnt != '1)     sb_cnt   <= sb_cnt + 1'b1;
            if (out_db_err && db_cnt != '1)     db_cnt   <= db_cnt + 1'b1;
            if (out_addr_err && addr_cnt != '1) addr_cnt <= addr_cnt + 1'b1;
        end
    end
`endif

endmodule
